// File: rtl/da_fir_pkg.sv
// Shared types and helpers for the DA FIR filter
// and its run-time partial-sum table loader.
package da_fir_pkg;

  localparam int COEFF_W = 17;
  localparam int LUT_W   = 19;
  localparam int ADDR_W  = 3;
  localparam int DEPTH   = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    BUILD,
    SWAP
  } ld_state_e;

  typedef logic signed [COEFF_W-1:0] coef_t;
  typedef logic signed [LUT_W-1:0]   lut_t;

  // Partial sum of the coefficients selected by the set bits of k.
  function automatic lut_t da_psum(
    input logic [ADDR_W-1:0] k,
    input coef_t             c0,
    input coef_t             c1,
    input coef_t             c2
  );
    lut_t s;
    s = '0;
    if (k[0]) s = s + lut_t'(c0);
    if (k[1]) s = s + lut_t'(c1);
    if (k[2]) s = s + lut_t'(c2);
    return s;
  endfunction

endpackage

// File: rtl/da_lut_bank.sv
// Double-buffered partial-sum table: shadow write
// port, atomic bank swap, registered negating reads.
module da_lut_bank
  import da_fir_pkg::*;
#(
  parameter int NUM_RD = 13
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  lut_t                     wr_data,
  input  logic                     swap,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic [NUM_RD-1:0]        rd_neg,
  output logic [NUM_RD*LUT_W-1:0]  rd_data
);

  lut_t                    bank_q [2][DEPTH];
  lut_t                    bank_d [2][DEPTH];
  logic                    sel_q, sel_d;
  logic [NUM_RD*LUT_W-1:0] rd_q, rd_d;

  // Writes go only to the bank not being read.
  always_comb begin
    bank_d = bank_q;
    sel_d  = sel_q ^ swap;
    if (wr_en) bank_d[~sel_q][wr_addr] = wr_data;
  end

  // Read the active bank, negating on request.
  always_comb begin
    rd_d = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (rd_neg[i])
        rd_d[i*LUT_W +: LUT_W] =
          -bank_q[sel_q][rd_addr[i*ADDR_W +: ADDR_W]];
      else
        rd_d[i*LUT_W +: LUT_W] =
          bank_q[sel_q][rd_addr[i*ADDR_W +: ADDR_W]];
    end
  end

  // Table, bank select and read registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q <= '{default: '0};
      sel_q  <= 1'b0;
      rd_q   <= '0;
    end else begin
      bank_q <= bank_d;
      sel_q  <= sel_d;
      rd_q   <= rd_d;
    end
  end

  assign rd_data = rd_q;

endmodule

// File: rtl/da_lut_loader.sv
// Accepts three folded coefficients, builds the
// 8-entry DA table in the shadow bank, then swaps.
module da_lut_loader
  import da_fir_pkg::*;
#(
  parameter int NUM_RD = 13
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     coef_valid,
  output logic                     coef_ready,
  input  logic [COEFF_W-1:0]       coef_data,
  output logic                     load_done,
  output logic                     table_valid,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic [NUM_RD-1:0]        rd_neg,
  output logic [NUM_RD*LUT_W-1:0]  rd_data
);

  ld_state_e         state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [ADDR_W-1:0] k_q, k_d;
  coef_t             coef_q [3];
  coef_t             coef_d [3];
  logic              done_q, done_d;
  logic              tv_q, tv_d;
  logic              accept;
  logic              wr_en;
  logic              swap;
  lut_t              wr_data;

  assign accept = coef_valid && coef_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: three words in, eight builds, one swap.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = LOAD;
      LOAD:    if (accept && idx_q == 2'd2) state_d = BUILD;
      BUILD:   if (k_q == ADDR_W'(DEPTH-1)) state_d = SWAP;
      SWAP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded controls; no accepts while in reset.
  always_comb begin
    coef_ready = 1'b0;
    wr_en      = 1'b0;
    swap       = 1'b0;
    unique case (state_q)
      IDLE, LOAD: coef_ready = !rst;
      BUILD:      wr_en      = 1'b1;
      SWAP:       swap       = 1'b1;
      default:    ;
    endcase
  end

  // Coefficient capture, build counter and status.
  always_comb begin
    idx_d  = idx_q;
    k_d    = k_q;
    coef_d = coef_q;
    done_d = swap;
    tv_d   = tv_q | swap;
    if (accept) begin
      case (idx_q)
        2'd0:    coef_d[0] = coef_t'(coef_data);
        2'd1:    coef_d[1] = coef_t'(coef_data);
        default: coef_d[2] = coef_t'(coef_data);
      endcase
      idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end
    if (wr_en) k_d = k_q + ADDR_W'(1);
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      k_q    <= '0;
      coef_q <= '{default: '0};
      done_q <= 1'b0;
      tv_q   <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      k_q    <= k_d;
      coef_q <= coef_d;
      done_q <= done_d;
      tv_q   <= tv_d;
    end
  end

  assign wr_data =
    da_psum(k_q, coef_q[0], coef_q[1], coef_q[2]);

  assign load_done   = done_q;
  assign table_valid = tv_q;

  da_lut_bank #(
    .NUM_RD (NUM_RD)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (k_q),
    .wr_data (wr_data),
    .swap    (swap),
    .rd_addr (rd_addr),
    .rd_neg  (rd_neg),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_da_lut_loader.sv
// Directed + randomized bench for da_lut_loader
// against a table-level reference model.
module tb_da_lut_loader;
  import da_fir_pkg::*;

  localparam int NRD = 13;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               coef_valid = 1'b0;
  logic               coef_ready;
  logic [COEFF_W-1:0] coef_data = '0;
  logic               load_done;
  logic               table_valid;
  logic [NRD*3-1:0]   rd_addr = '0;
  logic [NRD-1:0]     rd_neg = '0;
  logic [NRD*LUT_W-1:0] rd_data;

  int nchk = 0;
  int nerr = 0;
  int act [8];
  int pend [8];
  int ra [NRD];
  bit rn [NRD];
  bit tv_m = 0;
  int lit [8] = '{0, 7567, 20406, 27973,
                  32768, 40335, 53174, 60741};

  da_lut_loader #(.NUM_RD(NRD)) dut (
    .clk         (clk),
    .rst         (rst),
    .coef_valid  (coef_valid),
    .coef_ready  (coef_ready),
    .coef_data   (coef_data),
    .load_done   (load_done),
    .table_valid (table_valid),
    .rd_addr     (rd_addr),
    .rd_neg      (rd_neg),
    .rd_data     (rd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic int psum(int k, int a, int b, int c);
    int s = 0;
    if (k % 2 == 1) s += a;
    if ((k / 2) % 2 == 1) s += b;
    if (k / 4 == 1) s += c;
    return s;
  endfunction

  function automatic int rnd_coef();
    return int'($urandom_range(0, 131071)) - 65536;
  endfunction

  function automatic int port_val(int i);
    logic signed [LUT_W-1:0] v;
    v = rd_data[LUT_W*i +: LUT_W];
    return int'(v);
  endfunction

  function automatic int exp_port(int i, bit newt);
    int v;
    v = newt ? pend[ra[i]] : act[ra[i]];
    return rn[i] ? -v : v;
  endfunction

  task automatic chk(string tag, int obs, int exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic chk_ports(string tag, bit newt);
    for (int i = 0; i < NRD; i++)
      chk($sformatf("%s_p%0d", tag, i),
          port_val(i), exp_port(i, newt));
  endtask

  task automatic apply_rd();
    for (int i = 0; i < NRD; i++) begin
      rd_addr[3*i +: 3] = 3'(ra[i]);
      rd_neg[i] = rn[i];
    end
  endtask

  task automatic rand_rd();
    for (int i = 0; i < NRD; i++) begin
      ra[i] = int'($urandom_range(0, 7));
      rn[i] = 1'($urandom_range(0, 1));
    end
    apply_rd();
  endtask

  task automatic set_pend(int a, int b, int c);
    for (int k = 0; k < 8; k++) pend[k] = psum(k, a, b, c);
  endtask

  // Starts and ends 1 time unit after a rising edge.
  task automatic push(int c, int gap);
    int n = 0;
    bit got = 0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    coef_valid = 1'b1;
    coef_data = COEFF_W'(c);
    while (!got && n < 40) begin
      @(negedge clk);
      if (coef_ready) got = 1;
      else n++;
    end
    if (!got) chk("push_timeout", int'(coef_ready), 1);
    @(posedge clk);
    #1;
    coef_valid = 1'b0;
  endtask

  // Negedge k follows edge t+k, t = third accept edge.
  task automatic finish_load(bit hold, int hw);
    if (hold) begin
      coef_valid = 1'b1;
      coef_data = COEFF_W'(hw);
    end
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      chk($sformatf("ready_k%0d", k),
          int'(coef_ready), int'(k >= 9));
      chk($sformatf("done_k%0d", k),
          int'(load_done), int'(k == 9));
      chk($sformatf("tv_k%0d", k),
          int'(table_valid), int'(tv_m || k >= 9));
      chk_ports($sformatf("ld_k%0d", k), k >= 10);
    end
    act = pend;
    tv_m = 1;
    if (hold) coef_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic load(int a, int b, int c,
                      int g0, int g1, int g2);
    set_pend(a, b, c);
    push(a, g0);
    push(b, g1);
    push(c, g2);
    finish_load(0, 0);
  endtask

  task automatic rand_reads(int n);
    repeat (n) begin
      rand_rd();
      @(posedge clk);
      @(negedge clk);
      chk_ports("rr", 0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic port0_scan(string tag);
    for (int a = 0; a < 8; a++) begin
      ra[0] = a;
      rn[0] = 0;
      apply_rd();
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("%s_a%0d", tag, a), port_val(0), lit[a]);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int h [3];
    int w [3];
    for (int k = 0; k < 8; k++) begin
      act[k] = 0;
      pend[k] = 0;
    end
    // Reset
    rand_rd();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", int'(coef_ready), 0);
    chk("rst_done", int'(load_done), 0);
    chk("rst_tv", int'(table_valid), 0);
    chk_ports("rst_rd", 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", int'(coef_ready), 1);
    @(posedge clk);
    #1;
    rand_reads(2);

    // Back-to-back load, directed table
    load(7567, 20406, 32768, 0, 0, 0);
    port0_scan("t1");

    // Negated port 12, then all ports distinct
    ra[12] = 7;
    rn[12] = 1;
    apply_rd();
    @(posedge clk);
    @(negedge clk);
    chk("p12_neg_a7", port_val(12), -60741);
    ra[12] = 0;
    apply_rd();
    @(posedge clk);
    @(negedge clk);
    chk("p12_neg_a0", port_val(12), 0);
    for (int i = 0; i < NRD; i++) begin
      ra[i] = i % 8;
      rn[i] = 1'($urandom_range(0, 1));
    end
    apply_rd();
    @(posedge clk);
    @(negedge clk);
    chk_ports("all13", 0);
    @(posedge clk);
    #1;

    // Reload -1,-1,-1 while port 0 reads address 7
    ra[0] = 7;
    rn[0] = 0;
    apply_rd();
    load(-1, -1, -1, 1, 0, 0);
    chk("reload_a7", exp_port(0, 0), -3);

    // Reset during BUILD cycle 4
    rand_rd();
    set_pend(rnd_coef(), rnd_coef(), rnd_coef());
    push(5, 0);
    push(6, 0);
    push(7, 0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready", int'(coef_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 8; k++) act[k] = 0;
    tv_m = 0;
    repeat (12) begin
      @(negedge clk);
      chk("midrst_done", int'(load_done), 0);
      chk("midrst_tv", int'(table_valid), 0);
      chk_ports("midrst_rd", 0);
      rand_rd();
    end
    @(posedge clk);
    #1;

    // Gapped load gives the same table
    load(7567, 20406, 32768, 0, 5, 1);
    port0_scan("gap");

    // Valid held through load; 4th word waits for IDLE
    for (int j = 0; j < 3; j++) begin
      h[j] = rnd_coef();
      w[j] = rnd_coef();
    end
    rand_rd();
    set_pend(h[0], h[1], h[2]);
    push(h[0], 0);
    push(h[1], 0);
    push(h[2], 0);
    finish_load(1, w[0]);
    set_pend(w[0], w[1], w[2]);
    push(w[1], 0);
    push(w[2], 0);
    finish_load(0, 0);
    rand_reads(3);

    // Random loads with random gaps
    repeat (4) begin
      for (int j = 0; j < 3; j++) h[j] = rnd_coef();
      rand_rd();
      load(h[0], h[1], h[2],
           int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)));
      rand_reads(4);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule

// File: doc/da_lut_loader.md
Name: da_lut_loader

Overview:
- Run-time writer for the distributed-arithmetic partial-sum tables used by the symmetric 6-tap DA FIR datapath.
- Accepts the three folded coefficients (coeff0, coeff1, coeff2) over a valid/ready stream.
- Builds the 8-entry partial-sum table in a shadow bank, then swaps banks atomically.
- Serves NUM_RD registered read ports, one per DA bit-slice, so the filter datapath reads the table instead of using hard-coded constants.

Parameters:
- COEFF_W, 17, signed coefficient width.
- LUT_W, 19, signed table entry width (COEFF_W+2; holds the sum of 3 coefficients and its negation).
- NUM_RD, 13, number of parallel read ports (one per bit of the 13-bit pre-added sample).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- coef_valid  in  1  coefficient word present.
- coef_ready  out  1  loader accepts a coefficient this cycle.
- coef_data  in  COEFF_W  signed coefficient; words arrive in order coeff0, coeff1, coeff2.
- load_done  out  1  one-cycle pulse when a new table becomes active.
- table_valid  out  1  an active table has been loaded since reset.
- rd_addr  in  NUM_RD*3  per-port address {bit of add2, bit of add1, bit of add0}; port i at [3i+2:3i].
- rd_neg  in  NUM_RD  per-port negate request (set for the sign-bit slice).
- rd_data  out  NUM_RD*LUT_W  per-port registered signed entry; port i at [LUT_W*(i+1)-1:LUT_W*i].

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state IDLE, coefficient index 0, coefficient registers 0, both banks all-zero, active bank 0, coef_ready 0 while rst=1, load_done 0, table_valid 0, rd_data 0.
- States and transitions:
  - IDLE: coef_ready=1. A handshake stores coeff0, sets index to 1, and moves to LOAD.
  - LOAD: coef_ready=1. A handshake stores coef_data at index 1 or 2. After index 2 is accepted, move to BUILD with build counter k=0.
  - BUILD: coef_ready=0. Each cycle write shadow[k] = sum of coeff_j over every set bit j of k (sign-extended to LUT_W), then k++. After k=7, move to SWAP. Exactly 8 cycles.
  - SWAP: coef_ready=0. Flip active bank, pulse load_done=1, set table_valid=1, return to IDLE.
- Handshake:
  - A transfer occurs when coef_valid && coef_ready on a rising edge.
  - coef_valid asserted during BUILD or SWAP is not accepted; the word is held by the source.
  - Gaps between words in LOAD are allowed with no timeout.
- Latency: the third coefficient is accepted at edge t. BUILD occupies t+1..t+8, SWAP is t+9, and load_done is high in cycle t+10 (registered). Reads issued from cycle t+10 return the new table.
- Read ports:
  - Registered, 1-cycle latency: rd_data_i <= rd_neg_i ? -active[rd_addr_i] : active[rd_addr_i].
  - Reads are unaffected by BUILD writes because those target the shadow bank.
  - Reads in the cycle of the bank flip return the old table; no torn tables.
- Arithmetic: all sums are signed, sign-extended to LUT_W, with no saturation. Negation of the full-width LUT_W value cannot overflow for COEFF_W-bit inputs.
- Before the first completed load: every read returns 0 and table_valid=0.
- Reload: a new 3-word load may start any time in IDLE. table_valid stays 1 and the old table stays active until the next SWAP.
- Reset mid-LOAD or mid-BUILD: the load is aborted, both banks are cleared, table_valid=0, and no load_done pulse is produced.

Decomposition:
- Package da_fir_pkg holds:
  - COEFF_W, LUT_W, and ADDR_W=3.
  - The loader state enum {IDLE, LOAD, BUILD, SWAP}.
  - A function computing the partial sum for address k from three coefficients, shared with the filter's reference model.
- Sub-module da_lut_bank holds the two 8xLUT_W banks, the write port, the bank select, and the NUM_RD registered negating read ports.
- da_lut_loader holds the FSM, coefficient registers, and counters.

Test Plan:
- Load 7567, 20406, 32768 back-to-back, then read addresses 0..7 on port 0 -> 0, 7567, 20406, 27973, 32768, 40335, 53174, 60741. load_done is high exactly 10 cycles after the third accept edge.
- Same table, port 12 with rd_neg=1 at address 7 -> -60741; address 0 -> 0. All 13 ports read distinct addresses in the same cycle and each returns its correct value.
- Hold coef_valid high through the whole load -> exactly 3 words accepted, coef_ready=0 for 9 cycles (BUILD+SWAP), and the 4th word is accepted only after return to IDLE.
- Reload with -1, -1, -1 while port 0 continuously reads address 7 -> 60741 until the flip, then -3. No intermediate value appears. table_valid stays 1.
- Assert rst during BUILD cycle 4 -> after reset all reads return 0, table_valid=0, no load_done pulse. A subsequent full load succeeds.
- Insert idle gaps of 0, 5 and 1 cycles between coefficients -> same final table as back-to-back loading.
